pulse_count_ctrl: RTL and testbench
===================================

PULSE_COUNT_CTRL -- requirements
Module: pulse_count_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of independent channels (1..16).
REQ-002 Parameter CNT_W, default 8, SHALL set the per-channel count width in bits (2..16).
REQ-003 Parameter TMO_CYC, default 255, SHALL set the DWAIT timeout in cycles; 0 disables the timeout.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 eng  input  NUM_CH  per-channel arm/restart request, sampled at clk.
REQ-007 d_s  input  NUM_CH  per-channel data strobe, sampled at clk.
REQ-008 ack  input  NUM_CH  per-channel result acknowledge, sampled at clk.
REQ-009 waiting  output  NUM_CH  SHALL be high while the channel is in DWAIT.
REQ-010 counting  output  NUM_CH  SHALL be high while the channel is in COUNT.
REQ-011 data_ready  output  NUM_CH  SHALL be high while the channel is in DONE.
REQ-012 timed_out  output  NUM_CH  SHALL be high while the channel is in TMO.
REQ-013 count  output  NUM_CH*CNT_W  SHALL carry the per-channel count; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-014 ovf  output  NUM_CH  SHALL be the per-channel sticky saturation flag.

Function
REQ-015 Each channel SHALL run an independent FSM with states IDLE, DWAIT, COUNT, DONE and TMO, with no cross-channel interaction.
REQ-016 In IDLE: eng=1 SHALL move to DWAIT and clear count, ovf and the wait timer; otherwise the channel holds.
REQ-017 In DWAIT: d_s=1 SHALL move to COUNT with count=1, taking priority over timeout.
REQ-018 In DWAIT: the wait timer SHALL increment once per cycle; on the cycle it equals TMO_CYC-1 with d_s=0 (TMO_CYC>0), the channel SHALL move to TMO.
REQ-019 In DWAIT: eng=1 SHALL restart the wait timer at 0 and keep the channel in DWAIT.
REQ-020 In COUNT: eng=1 SHALL move to DWAIT and clear count and ovf; this has priority over every other input.
REQ-021 In COUNT: with eng=0 and d_s=1, count SHALL increment by 1; at all-ones it SHALL hold and set ovf.
REQ-022 In COUNT: with eng=0 and d_s=0, the channel SHALL move to DONE with count frozen.
REQ-023 In DONE and TMO: eng=1 SHALL move to DWAIT (clearing count, ovf and timer); otherwise ack=1 SHALL move to IDLE.
REQ-024 When eng and ack are both high, eng SHALL win.
REQ-025 In IDLE, count and ovf SHALL hold their last values so the result stays readable after ack.
REQ-026 Status outputs SHALL be a Moore decode of the registered state; for any given channel, exactly one of waiting/counting/data_ready/timed_out SHALL be high, or none of them in IDLE.
REQ-027 Latency: a state change caused by the inputs at edge N SHALL be visible on the outputs immediately after edge N.
REQ-028 The count SHALL equal the number of consecutive sampled d_s=1 cycles, beginning with the DWAIT-to-COUNT edge.

Reset
REQ-029 While rst=1, every channel SHALL be in IDLE with count=0, ovf=0, timer=0 and all status outputs 0, independent of clk.
REQ-030 Assertion of rst mid-operation SHALL abort all channels immediately; the first edge after deassertion SHALL evaluate the IDLE transitions.

Structure
REQ-031 A shared package pcc_pkg SHALL hold the state enum (pcc_state_t: IDLE, DWAIT, COUNT, DONE, TMO) and the default parameter constants.
REQ-032 The per-channel FSM, counter and timer SHALL live in sub-module pcc_channel, instantiated NUM_CH times by a generate loop.
REQ-033 The timer width SHALL be $clog2(TMO_CYC+1), with a minimum of 1.

Verification
REQ-034 Ch0: eng pulse, d_s high for 5 cycles then low -> waiting for 1 cycle, counting for 5, data_ready with count=5; ack returns the channel to IDLE with count still 5.
REQ-035 CNT_W=4: d_s held high for 20 cycles -> count saturates at 15 and ovf=1; after d_s falls, data_ready=1.
REQ-036 TMO_CYC=10: eng pulse, d_s held low -> timed_out rises exactly 10 cycles after entering DWAIT; ack returns the channel to IDLE.
REQ-037 Ch1 in DONE with eng=1 and ack=1 in the same cycle -> DWAIT, count=0.
REQ-038 Ch2 in COUNT at count=3 with eng=1 -> waiting=1 and count=0 on the next cycle, while ch3 running concurrently is unaffected.
REQ-039 rst asserted between clock edges with all channels in COUNT -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/pcc_pkg.sv
// Shared types and default constants for the multi-channel pulse counter.
// pcc_tmr_w sizes the DWAIT timer so that it can reach TMO_CYC-1.
package pcc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DWAIT = 3'd1,
        COUNT = 3'd2,
        DONE  = 3'd3,
        TMO   = 3'd4
    } pcc_state_t;

    localparam int PCC_NUM_CH_DEF  = 4;
    localparam int PCC_CNT_W_DEF   = 8;
    localparam int PCC_TMO_CYC_DEF = 255;

    function automatic int pcc_tmr_w(input int tmo_cyc);
        int w;
        w = $clog2(tmo_cyc + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pcc_channel.sv
// One pulse-count channel: arm, wait for the first strobe (with timeout),
// count consecutive strobes with saturation, then hold the result until ack.
//
// state | meaning
// IDLE  | parked; last count/ovf stay readable
// DWAIT | armed, waiting for first d_s; timer running
// COUNT | counting consecutive d_s cycles
// DONE  | d_s fell; result frozen until ack or re-arm
// TMO   | no d_s within TMO_CYC cycles; waiting for ack or re-arm
module pcc_channel
    import pcc_pkg::*;
#(
    parameter int CNT_W   = PCC_CNT_W_DEF,
    parameter int TMO_CYC = PCC_TMO_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             eng,
    input  logic             d_s,
    input  logic             ack,
    output logic             waiting,
    output logic             counting,
    output logic             data_ready,
    output logic             timed_out,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam int               TMR_W    = pcc_tmr_w(TMO_CYC);
    localparam bit               TMO_EN   = (TMO_CYC > 0);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

    pcc_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            ovf_q   <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: begin
                if (eng) begin
                    state_d = DWAIT;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    tmr_d   = '0;
                end
            end
            DWAIT: begin
                // A re-arm only restarts the wait window.
                if (eng) begin
                    tmr_d = '0;
                end else if (d_s) begin
                    state_d = COUNT;
                    count_d = CNT_W'(1);
                end else if (TMO_EN && (tmr_q == TMR_LAST)) begin
                    state_d = TMO;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            COUNT: begin
                if (eng) begin
                    state_d = DWAIT;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    tmr_d   = '0;
                end else if (d_s) begin
                    if (&count_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    state_d = DONE;
                end
            end
            DONE, TMO: begin
                if (eng) begin
                    state_d = DWAIT;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    tmr_d   = '0;
                end else if (ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign waiting    = (state_q == DWAIT);
    assign counting   = (state_q == COUNT);
    assign data_ready = (state_q == DONE);
    assign timed_out  = (state_q == TMO);
    assign count      = count_q;
    assign ovf        = ovf_q;

endmodule

// File: rtl/pulse_count_ctrl.sv
// Array of independent pulse-count channels sharing clk and rst.
// Channel i drives count[i*CNT_W +: CNT_W] and bit i of every status vector.
module pulse_count_ctrl
    import pcc_pkg::*;
#(
    parameter int NUM_CH  = PCC_NUM_CH_DEF,
    parameter int CNT_W   = PCC_CNT_W_DEF,
    parameter int TMO_CYC = PCC_TMO_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       eng,
    input  logic [NUM_CH-1:0]       d_s,
    input  logic [NUM_CH-1:0]       ack,
    output logic [NUM_CH-1:0]       waiting,
    output logic [NUM_CH-1:0]       counting,
    output logic [NUM_CH-1:0]       data_ready,
    output logic [NUM_CH-1:0]       timed_out,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       ovf
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pcc_channel #(
            .CNT_W   (CNT_W),
            .TMO_CYC (TMO_CYC)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .eng        (eng[g]),
            .d_s        (d_s[g]),
            .ack        (ack[g]),
            .waiting    (waiting[g]),
            .counting   (counting[g]),
            .data_ready (data_ready[g]),
            .timed_out  (timed_out[g]),
            .count      (count[g*CNT_W +: CNT_W]),
            .ovf        (ovf[g])
        );
    end

endmodule

// File: tb/tb_pulse_count_ctrl.sv
// Bench for pulse_count_ctrl: a short-timeout/4-bit instance and a default
// instance share stimulus; directed vectors, corner sequences, random vs model.
module tb_pulse_count_ctrl;

    localparam int NCH   = 4;
    localparam int CW_S  = 4;
    localparam int TMO_S = 10;
    localparam int CW_D  = 8;
    localparam int TMO_D = 255;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_CNT  = 2;
    localparam int M_DONE = 3;
    localparam int M_TMO  = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NCH-1:0] eng, d_s, ack;

    logic [NCH-1:0]      wt_s, cn_s, rd_s, to_s, ovf_s;
    logic [NCH*CW_S-1:0] cnt_s;
    logic [NCH-1:0]      wt_d, cn_d, rd_d, to_d, ovf_d;
    logic [NCH*CW_D-1:0] cnt_d;

    int n_chk = 0;
    int n_err = 0;

    int m_mode [2][NCH];
    int m_cnt  [2][NCH];
    int m_ovf  [2][NCH];
    int m_wait [2][NCH];
    bit run    [NCH];

    always #5 clk = ~clk;

    pulse_count_ctrl #(.NUM_CH(NCH), .CNT_W(CW_S), .TMO_CYC(TMO_S)) dut_s (
        .clk(clk), .rst(rst), .eng(eng), .d_s(d_s), .ack(ack),
        .waiting(wt_s), .counting(cn_s), .data_ready(rd_s), .timed_out(to_s),
        .count(cnt_s), .ovf(ovf_s)
    );

    pulse_count_ctrl #(.NUM_CH(NCH), .CNT_W(CW_D), .TMO_CYC(TMO_D)) dut_d (
        .clk(clk), .rst(rst), .eng(eng), .d_s(d_s), .ack(ack),
        .waiting(wt_d), .counting(cn_d), .data_ready(rd_d), .timed_out(to_d),
        .count(cnt_d), .ovf(ovf_d)
    );

    typedef struct {
        logic [3:0] eng;
        logic [3:0] d_s;
        logic [3:0] ack;
        logic [3:0] w;
        logic [3:0] c;
        logic [3:0] r;
        logic [3:0] t;
        int         cnt0;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(input logic [3:0] e, input logic [3:0] s, input logic [3:0] a,
                                input logic [3:0] w, input logic [3:0] c, input logic [3:0] r,
                                input logic [3:0] t, input int n);
        vec_t v;
        v.eng = e; v.d_s = s; v.ack = a;
        v.w = w; v.c = c; v.r = r; v.t = t; v.cnt0 = n;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        eng = '0; d_s = '0; ack = '0;
        step();
        rst = 1'b0;
    endtask

    // status as {waiting, counting, data_ready, timed_out}
    function automatic int stat_of(input int d, input int ch);
        if (d == 0) return int'({wt_s[ch], cn_s[ch], rd_s[ch], to_s[ch]});
        return int'({wt_d[ch], cn_d[ch], rd_d[ch], to_d[ch]});
    endfunction

    function automatic int cnt_of(input int d, input int ch);
        if (d == 0) return int'(cnt_s[ch*CW_S +: CW_S]);
        return int'(cnt_d[ch*CW_D +: CW_D]);
    endfunction

    function automatic int ovf_of(input int d, input int ch);
        if (d == 0) return int'(ovf_s[ch]);
        return int'(ovf_d[ch]);
    endfunction

    function automatic int mode_stat(input int m);
        case (m)
            M_WAIT:  return 8;
            M_CNT:   return 4;
            M_DONE:  return 2;
            M_TMO:   return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_arm(input int d, input int ch);
        m_mode[d][ch] = M_WAIT;
        m_cnt[d][ch]  = 0;
        m_ovf[d][ch]  = 0;
        m_wait[d][ch] = 0;
    endtask

    // m_wait = number of strobe-less cycles already spent waiting
    task automatic model_step(input int d, input int ch, input bit e, input bit s, input bit a);
        int cmax;
        int tmo;
        cmax = (d == 0) ? (1 << CW_S) - 1 : (1 << CW_D) - 1;
        tmo  = (d == 0) ? TMO_S : TMO_D;
        case (m_mode[d][ch])
            M_IDLE: if (e) model_arm(d, ch);
            M_WAIT: begin
                if (e) m_wait[d][ch] = 0;
                else if (s) begin
                    m_mode[d][ch] = M_CNT;
                    m_cnt[d][ch]  = 1;
                end else begin
                    m_wait[d][ch]++;
                    if (tmo > 0 && m_wait[d][ch] >= tmo) m_mode[d][ch] = M_TMO;
                end
            end
            M_CNT: begin
                if (e) model_arm(d, ch);
                else if (s) begin
                    if (m_cnt[d][ch] >= cmax) m_ovf[d][ch] = 1;
                    m_cnt[d][ch] = (m_cnt[d][ch] + 1 > cmax) ? cmax : m_cnt[d][ch] + 1;
                end else m_mode[d][ch] = M_DONE;
            end
            default: begin
                if (e) model_arm(d, ch);
                else if (a) m_mode[d][ch] = M_IDLE;
            end
        endcase
    endtask

    initial begin
        rst = 1'b1;
        eng = '0; d_s = '0; ack = '0;

        tbl[0]  = mk(4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0);
        tbl[1]  = mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1);
        tbl[2]  = mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 2);
        tbl[3]  = mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 3);
        tbl[4]  = mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4);
        tbl[5]  = mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 5);
        tbl[6]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 5);
        tbl[7]  = mk(4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 5);
        tbl[8]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5);
        tbl[9]  = mk(4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 5);
        tbl[10] = mk(4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0);

        // reset state
        repeat (2) step();
        check("rst_status_s", int'({wt_s, cn_s, rd_s, to_s}), 0);
        check("rst_status_d", int'({wt_d, cn_d, rd_d, to_d}), 0);
        check("rst_count_s", int'(cnt_s), 0);
        check("rst_ovf_s", int'(ovf_s), 0);
        rst = 1'b0;

        // directed vector table: ch0 pulse burst of 5, ack, idle hold
        for (int i = 0; i < 11; i++) begin
            eng = tbl[i].eng; d_s = tbl[i].d_s; ack = tbl[i].ack;
            step();
            check($sformatf("tbl%0d_status", i), int'({wt_s, cn_s, rd_s, to_s}),
                  int'({tbl[i].w, tbl[i].c, tbl[i].r, tbl[i].t}));
            check($sformatf("tbl%0d_count0", i), cnt_of(0, 0), tbl[i].cnt0);
        end

        // saturation on the 4-bit instance
        do_reset();
        eng = 4'h1; step();
        eng = 4'h0; d_s = 4'h1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 15) begin
                check("sat_reach_cnt", cnt_of(0, 0), 15);
                check("sat_reach_ovf", ovf_of(0, 0), 0);
            end
        end
        check("sat_cnt", cnt_of(0, 0), 15);
        check("sat_ovf", ovf_of(0, 0), 1);
        check("sat_counting", stat_of(0, 0), 4);
        check("sat_wide_cnt", cnt_of(1, 0), 20);
        check("sat_wide_ovf", ovf_of(1, 0), 0);
        d_s = 4'h0; step();
        check("sat_done", stat_of(0, 0), 2);
        check("sat_done_cnt", cnt_of(0, 0), 15);
        check("sat_done_ovf", ovf_of(0, 0), 1);

        // timeout exactly TMO_S cycles after entering DWAIT
        do_reset();
        eng = 4'h1; step();
        eng = 4'h0;
        for (int k = 1; k <= TMO_S; k++) begin
            step();
            check($sformatf("tmo_k%0d", k), int'(to_s[0]), (k == TMO_S) ? 1 : 0);
        end
        check("tmo_wide_waiting", stat_of(1, 0), 8);
        ack = 4'h1; step();
        ack = 4'h0;
        check("tmo_ack_idle", stat_of(0, 0), 0);

        // eng beats ack in DONE
        do_reset();
        eng = 4'h2; step();
        eng = 4'h0; d_s = 4'h2;
        repeat (2) step();
        d_s = 4'h0; step();
        check("ea_done", stat_of(0, 1), 2);
        check("ea_done_cnt", cnt_of(0, 1), 2);
        eng = 4'h2; ack = 4'h2; step();
        eng = 4'h0; ack = 4'h0;
        check("ea_rearm", stat_of(0, 1), 8);
        check("ea_rearm_cnt", cnt_of(0, 1), 0);

        // restart ch2 mid-count while ch3 keeps counting
        do_reset();
        eng = 4'hC; step();
        eng = 4'h0; d_s = 4'hC;
        repeat (3) step();
        check("rs_cnt2", cnt_of(0, 2), 3);
        check("rs_cnt3", cnt_of(0, 3), 3);
        eng = 4'h4; step();
        eng = 4'h0; d_s = 4'h0;
        check("rs_ch2_wait", stat_of(0, 2), 8);
        check("rs_ch2_cnt", cnt_of(0, 2), 0);
        check("rs_ch3_cnt_state", stat_of(0, 3), 4);
        check("rs_ch3_cnt", cnt_of(0, 3), 4);

        // async reset between edges with every channel counting
        do_reset();
        eng = 4'hF; step();
        eng = 4'h0; d_s = 4'hF; step();
        check("ar_all_counting", int'(cn_s), 15);
        #2 rst = 1'b1;
        #1;
        check("ar_status_s", int'({wt_s, cn_s, rd_s, to_s}), 0);
        check("ar_status_d", int'({wt_d, cn_d, rd_d, to_d}), 0);
        check("ar_count_s", int'(cnt_s), 0);
        check("ar_count_d", int'(cnt_d), 0);
        d_s = 4'h0;
        step();
        check("ar_held", int'({wt_s, cn_s, rd_s, to_s, ovf_s}), 0);
        eng = 4'h1; rst = 1'b0;
        step();
        eng = 4'h0;
        check("ar_first_edge", int'({wt_s, cn_s, rd_s, to_s}), 16'h1000);

        // randomized traffic against the reference model
        do_reset();
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < NCH; ch++) begin
                m_mode[d][ch] = M_IDLE; m_cnt[d][ch] = 0;
                m_ovf[d][ch] = 0; m_wait[d][ch] = 0;
            end
        for (int ch = 0; ch < NCH; ch++) run[ch] = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                eng[ch] = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 5) == 0) run[ch] = ~run[ch];
                d_s[ch] = run[ch];
                ack[ch] = ($urandom_range(0, 3) == 0);
            end
            step();
            for (int d = 0; d < 2; d++)
                for (int ch = 0; ch < NCH; ch++) begin
                    model_step(d, ch, eng[ch], d_s[ch], ack[ch]);
                    check($sformatf("rnd_c%0d_d%0d_ch%0d_status", cyc, d, ch),
                          stat_of(d, ch), mode_stat(m_mode[d][ch]));
                    check($sformatf("rnd_c%0d_d%0d_ch%0d_count", cyc, d, ch),
                          cnt_of(d, ch), m_cnt[d][ch]);
                    check($sformatf("rnd_c%0d_d%0d_ch%0d_ovf", cyc, d, ch),
                          ovf_of(d, ch), m_ovf[d][ch]);
                end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
